// File: rtl/calc_pkg.sv
// Shared types for the calculator front end: operand nibble, entry FSM states
// and the LEDR pattern shown for each state.
package calc_pkg;

    typedef logic [3:0] nibble_t;

    typedef enum logic [1:0] {
        GET_A,
        GET_B,
        SHOW
    } entry_state_t;

    localparam logic [1:0] LED_GET_A = 2'b01;
    localparam logic [1:0] LED_GET_B = 2'b10;
    localparam logic [1:0] LED_SHOW  = 2'b11;

    function automatic logic [1:0] state_led(input entry_state_t s);
        case (s)
            GET_A:   return LED_GET_A;
            GET_B:   return LED_GET_B;
            SHOW:    return LED_SHOW;
            default: return LED_GET_A;
        endcase
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Active-low push-button conditioner: 2-FF synchronizer, saturating stability
// counter and a registered one-cycle pulse on each debounced press.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n_raw,
    output logic pressed,
    output logic press_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s2_q;
    logic             deb_q, deb_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        // The cycle that completes the stable run flips the level and rearms the counter.
        if (s2_q != deb_q) begin
            if (cnt_q >= CNT_LAST) begin
                deb_d = s2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        pulse_d = deb_q & ~deb_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            deb_q   <= 1'b1;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            s1_q    <= key_n_raw;
            s2_q    <= s1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pressed     = ~deb_q;
    assign press_pulse = pulse_q;

endmodule

// File: rtl/operand_entry.sv
// Two-press operand entry: captures A then B from the switches and publishes a
// stable {B,A} pair for the calculator's operand bus.
module operand_entry
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] SW_IN,
    input  logic       KEY_LOAD_N,
    input  logic       KEY_CLR_N,
    output logic [7:0] operands,
    output logic       op_valid,
    output logic [1:0] LEDR
);

    logic load_pulse, clr_pulse;
    logic load_held, clr_held;
    logic unused_held;

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load (
        .clk         (clk),
        .reset       (reset),
        .key_n_raw   (KEY_LOAD_N),
        .pressed     (load_held),
        .press_pulse (load_pulse)
    );

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
        .clk         (clk),
        .reset       (reset),
        .key_n_raw   (KEY_CLR_N),
        .pressed     (clr_held),
        .press_pulse (clr_pulse)
    );

    assign unused_held = load_held & clr_held;

    nibble_t      sw_s1_q, sw_s2_q;
    entry_state_t state_q, state_d;
    nibble_t      a_q, a_d;
    logic [7:0]   ops_q, ops_d;
    logic         vld_q, vld_d;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        ops_d   = ops_q;
        vld_d   = vld_q;
        if (clr_pulse) begin
            state_d = GET_A;
            a_d     = '0;
            ops_d   = '0;
            vld_d   = 1'b0;
        end else if (load_pulse) begin
            case (state_q)
                GET_A: begin
                    a_d     = sw_s2_q;
                    state_d = GET_B;
                end
                GET_B: begin
                    ops_d   = {sw_s2_q, a_q};
                    vld_d   = 1'b1;
                    state_d = SHOW;
                end
                // Old pair stays on the bus until the new B completes it.
                SHOW: begin
                    a_d     = sw_s2_q;
                    vld_d   = 1'b0;
                    state_d = GET_B;
                end
                default: state_d = GET_A;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_s1_q <= '0;
            sw_s2_q <= '0;
            state_q <= GET_A;
            a_q     <= '0;
            ops_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            sw_s1_q <= SW_IN;
            sw_s2_q <= sw_s1_q;
            state_q <= state_d;
            a_q     <= a_d;
            ops_q   <= ops_d;
            vld_q   <= vld_d;
        end
    end

    assign operands = ops_q;
    assign op_valid = vld_q;
    assign LEDR     = state_led(state_q);

endmodule
